ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It is the counterpart to the keyboard receive path. It drives the shared ps2_clk/ps2_data lines open-drain through output-enable pins; the top level ties each line low when its _oe is high and releases it otherwise. The keyboard's reply bytes, such as 0xFA, come back through the existing receive path.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_sync_edge.sv | 16 +
 rtl/ps2_host_tx.sv | 94 +++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding and keyboard command/response bytes.
package ps2_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    DATA      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_t;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND  = 8'hFE;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 3-flop synchronizer for a PS/2 line plus one-cycle falling-edge strobe.
module ps2_sync_edge (
  input  logic clk,
  input  logic clrn,
  input  logic d,
  output logic level,
  output logic fall
);
  logic [2:0] s;
  // idle PS/2 lines are high, so reset to 1 to avoid a false edge after reset
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) s <= 3'b111;
    else s <= {s[1:0], d};
  assign level = s[1];
  assign fall  = s[2] & ~s[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter driving open-drain lines via output enables.
// Optional watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx import ps2_pkg::*; #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       ack_err,
  output logic       busy_rx_inhibit
);
  localparam int CW = $clog2(INHIBIT_CYCLES);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  ps2_tx_state_t state;
  logic [CW-1:0] cnt;
  logic [9:0] shreg;
  logic [3:0] bitcnt;
  logic dreg, clk_lvl, clk_fall, data_lvl, unused_data_fall, wd_hit;
  ps2_sync_edge u_clk_sync (.clk(clk), .clrn(clrn), .d(ps2_clk_in), .level(clk_lvl), .fall(clk_fall));
  ps2_sync_edge u_data_sync (.clk(clk), .clrn(clrn), .d(ps2_data_in), .level(data_lvl), .fall(unused_data_fall));
`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) wd <= '0;
    else wd <= (state == IDLE || state == INHIBIT || clk_fall || wd_hit) ? '0 : wd + 1'b1;
  assign wd_hit = wd == TO_LAST;
`else
  // watchdog compiled out: a silent device stalls in REQ until clrn
  assign wd_hit = TIMEOUT_CYCLES < 0;
`endif
  // The fall that ends REQ already presents bit 0, so a device clocking 11 edges sees 8 data, parity, stop, ACK.
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bitcnt  <= '0;
      dreg    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (tx_valid && tx_ready) begin
            shreg   <= {1'b1, ~^tx_data, tx_data};
            cnt     <= '0;
            bitcnt  <= '0;
            ack_err <= 1'b0;
            state   <= INHIBIT;
          end
        INHIBIT:
          if (cnt == INH_LAST) state <= REQ;
          else cnt <= cnt + 1'b1;
        REQ, DATA:
          if (clk_fall) begin
            dreg   <= ~shreg[bitcnt];
            bitcnt <= bitcnt + 4'd1;
            state  <= bitcnt == 4'd9 ? ACK : DATA;
          end
        ACK:
          if (clk_fall) begin
            ack_err <= data_lvl;
            state   <= WAIT_IDLE;
          end
        WAIT_IDLE:
          if (clk_lvl && data_lvl) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        default: state <= IDLE;
      endcase
      if (wd_hit) begin
        state   <= IDLE;
        dreg    <= 1'b0;
        done    <= 1'b1;
        ack_err <= 1'b1;
      end
    end
  assign tx_ready        = state == IDLE && !done;
  assign busy_rx_inhibit = state != IDLE;
  assign ps2_clk_oe      = state == INHIBIT;
  assign ps2_data_oe     = (state == INHIBIT && cnt == INH_LAST) || state == REQ || (state == DATA && dreg);
endmodule
